// File: rtl/mem_resp_if.sv
// mem_resp_if: core <-> memory responder request/response bundle.
//   master : core side, drives read/write/atomic/addr/store data, sees
//            registered load data, stall and error pulse.
//   slave  : responder side.
interface mem_resp_if;
  logic        mem_read;
  logic        mem_write;
  logic        mem_atomic;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_w;
  logic [31:0] mem_data_r;
  logic        mem_wait;
  logic        mem_err;

  modport master (
    output mem_read, mem_write, mem_atomic, mem_addr, mem_data_w,
    input  mem_data_r, mem_wait, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_atomic, mem_addr, mem_data_w,
    output mem_data_r, mem_wait, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed 32-bit memory model with a fixed stall.
//   Each access stalls the core for WAIT_CYCLES+1 cycles (IDLE accept cycle
//   plus WAIT_CYCLES in WAIT), then spends one DONE cycle with mem_wait low
//   and mem_data_r / mem_err valid.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (array contents are kept)
//   bus  - mem_resp_if.slave: mem_read/mem_write/mem_atomic/mem_addr/
//          mem_data_w in; mem_data_r (registered), mem_wait (comb), mem_err
//          (one-cycle pulse) out
// Parameters: ADDR_W (word-address width), WAIT_CYCLES (1..15).
// Optional feature: define MEM_RESP_ATOMIC_EN to build the LW.A/SW.A
//   reservation register; otherwise mem_atomic is ignored.
module mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  mem_resp_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        atomic_q, atomic_d;
  logic        err_q, err_d;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] idx;
  logic              acc_now;
  logic              acc_err;
  logic              is_sc;
  logic              sc_ok;
  logic              mem_we;

  assign idx     = addr_q[ADDR_W+1:2];
  // misaligned, out of range, or read+write together
  assign acc_err = (addr_q[1:0] != 2'b00) ||
                   ((addr_q >> (ADDR_W+2)) != 32'd0) ||
                   (rd_q && wr_q);
  // the access happens on the edge that leaves WAIT
  assign acc_now = (state_q == WAIT) && (cnt_q == 4'd1);

`ifdef MEM_RESP_ATOMIC_EN
  logic              resv_vld_q, resv_vld_d;
  logic [ADDR_W-1:0] resv_idx_q, resv_idx_d;

  assign is_sc = wr_q && atomic_q;
  assign sc_ok = resv_vld_q && (resv_idx_q == idx);

  always_comb begin
    resv_vld_d = resv_vld_q;
    resv_idx_d = resv_idx_q;
    if (acc_now && !acc_err) begin
      if (rd_q && atomic_q) begin
        resv_vld_d = 1'b1;
        resv_idx_d = idx;
      end else if (is_sc || (wr_q && sc_ok)) begin
        // any SW.A, or a plain store hitting the reserved word
        resv_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resv_vld_q <= 1'b0;
      resv_idx_q <= '0;
    end else begin
      resv_vld_q <= resv_vld_d;
      resv_idx_q <= resv_idx_d;
    end
  end
`else
  logic atomic_unused;
  assign atomic_unused = atomic_q;
  assign is_sc         = 1'b0;
  assign sc_ok         = 1'b0;
`endif

  // rst gate keeps a reset landing on the access edge from writing
  assign mem_we = acc_now && !acc_err && wr_q && (!is_sc || sc_ok) && !rst;

  assign bus.mem_wait   = !rst && (((state_q == IDLE) && (bus.mem_read || bus.mem_write)) ||
                                   (state_q == WAIT));
  assign bus.mem_data_r = rdata_q;
  assign bus.mem_err    = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    atomic_d = atomic_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          addr_d   = bus.mem_addr;
          wdata_d  = bus.mem_data_w;
          rd_d     = bus.mem_read;
          wr_d     = bus.mem_write;
          atomic_d = bus.mem_atomic;
          cnt_d    = 4'(WAIT_CYCLES);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          if (acc_err) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end else if (rd_q) begin
            rdata_d = mem[idx];
          end else if (is_sc) begin
            rdata_d = {31'd0, !sc_ok};
          end
        end
      end
      DONE:    state_d = IDLE;  // request still held by the core is ignored
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      atomic_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      atomic_q <= atomic_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven bench for mem_responder (ADDR_W=10,
// WAIT_CYCLES=2) with a scoreboard queue of expected DONE-cycle results,
// plus hand-written reset sequences.
module tb_mem_responder;
  localparam int ADDR_W      = 10;
  localparam int WAIT_CYCLES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_resp_if bus ();

  mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rd, wr, at;
    logic [31:0] addr, wd;
    logic        hold;      // store: mem_data_r keeps previous value
    logic [31:0] exp;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_r   = 32'd0;

  function automatic vec_t mk(logic rd, logic wr, logic at, logic [31:0] addr,
                              logic [31:0] wd, logic hold, logic [31:0] exp, logic err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.at = at; v.addr = addr; v.wd = wd;
    v.hold = hold; v.exp = exp; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic at,
                       input logic [31:0] addr, input logic [31:0] wd);
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.mem_atomic = at;
    bus.mem_addr   = addr;
    bus.mem_data_w = wd;
  endtask

  // Drive one access in the cycle after the previous DONE and check it.
  task automatic run_access(input int n, input vec_t v);
    exp_t e;
    int   waits;
    int   err_in_wait;
    bit   done;
    @(posedge clk); #1;
    drive(v.rd, v.wr, v.at, v.addr, v.wd);
    e.data = v.hold ? last_r : v.exp;
    e.err  = v.err;
    sb.push_back(e);
    waits = 0; err_in_wait = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_wait) begin
        waits++;
        if (bus.mem_err) err_in_wait++;
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL timeout vec %0d: mem_wait stuck high, expected DONE", n);
      void'(sb.pop_front());
      return;
    end
    chk($sformatf("wait_cycles[%0d]", n), 32'(waits), 32'(WAIT_CYCLES + 1));
    chk($sformatf("err_in_wait[%0d]", n), 32'(err_in_wait), 32'd0);
    e = sb.pop_front();
    chk($sformatf("data_r[%0d]", n), bus.mem_data_r, e.data);
    chk($sformatf("err[%0d]", n), {31'd0, bus.mem_err}, {31'd0, e.err});
    last_r = e.data;
  endtask

  initial begin
    // ---- vectors: rd wr at addr wd hold exp err ----
    vecs.push_back(mk(0,1,0, 32'h10,   32'hDEADBEEF, 1, 0,            0));
    vecs.push_back(mk(1,0,0, 32'h10,   0,            0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1,0,0, 32'h10,   0,            0, 32'hDEADBEEF, 0)); // back-to-back same load
    vecs.push_back(mk(1,0,0, 32'h13,   0,            0, 0,            1)); // misaligned
    vecs.push_back(mk(1,0,0, 32'h1000, 0,            0, 0,            1)); // out of range
    vecs.push_back(mk(0,1,0, 32'h1010, 32'h12345678, 0, 0,            1)); // would alias 0x10
    vecs.push_back(mk(0,1,0, 32'h11,   32'h0BADF00D, 0, 0,            1));
    vecs.push_back(mk(1,1,0, 32'h10,   32'h0BADF00D, 0, 0,            1)); // rd+wr together
    vecs.push_back(mk(1,0,0, 32'h10,   0,            0, 32'hDEADBEEF, 0)); // array unchanged
    vecs.push_back(mk(0,1,0, 32'h20,   32'h11111111, 1, 0,            0));
    vecs.push_back(mk(0,1,0, 32'hFFC,  32'hA5A5A5A5, 1, 0,            0)); // top word
    vecs.push_back(mk(1,0,0, 32'hFFC,  0,            0, 32'hA5A5A5A5, 0));
    vecs.push_back(mk(0,1,0, 32'h40,   32'h0,        1, 0,            0));
`ifdef MEM_RESP_ATOMIC_EN
    vecs.push_back(mk(1,0,1, 32'h40,   0,            0, 32'h0,        0)); // LW.A
    vecs.push_back(mk(0,1,1, 32'h40,   32'd5,        0, 32'd0,        0)); // SW.A ok
    vecs.push_back(mk(1,0,0, 32'h40,   0,            0, 32'd5,        0));
    vecs.push_back(mk(0,1,1, 32'h40,   32'd6,        0, 32'd1,        0)); // SW.A fails
    vecs.push_back(mk(1,0,0, 32'h40,   0,            0, 32'd5,        0));
    vecs.push_back(mk(1,0,1, 32'h40,   0,            0, 32'd5,        0)); // LW.A
    vecs.push_back(mk(0,1,0, 32'h40,   32'd7,        1, 0,            0)); // plain SW clears
    vecs.push_back(mk(0,1,1, 32'h40,   32'd8,        0, 32'd1,        0)); // SW.A fails
    vecs.push_back(mk(1,0,0, 32'h40,   0,            0, 32'd7,        0));
    vecs.push_back(mk(1,0,1, 32'h40,   0,            0, 32'd7,        0)); // LW.A
    vecs.push_back(mk(1,0,1, 32'h43,   0,            0, 32'd0,        1)); // erroring LW.A keeps resv
    vecs.push_back(mk(0,1,1, 32'h40,   32'd9,        0, 32'd0,        0)); // SW.A ok
    vecs.push_back(mk(1,0,0, 32'h40,   0,            0, 32'd9,        0));
`else
    vecs.push_back(mk(0,1,1, 32'h40,   32'd5,        1, 0,            0)); // SW.A as SW
    vecs.push_back(mk(1,0,1, 32'h40,   0,            0, 32'd5,        0)); // LW.A as LW
    vecs.push_back(mk(0,1,1, 32'h40,   32'd6,        1, 0,            0));
    vecs.push_back(mk(1,0,0, 32'h40,   0,            0, 32'd6,        0));
`endif

    // ---- reset state, request present while rst high ----
    drive(1, 0, 0, 32'h10, 0);
    #3;
    chk("rst_wait", {31'd0, bus.mem_wait}, 32'd0);
    chk("rst_data", bus.mem_data_r, 32'd0);
    chk("rst_err",  {31'd0, bus.mem_err}, 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;

    // ---- table, back-to-back ----
    foreach (vecs[i]) run_access(i, vecs[i]);

    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("idle_wait", {31'd0, bus.mem_wait}, 32'd0);
    chk("idle_err",  {31'd0, bus.mem_err}, 32'd0);
    chk("idle_data_hold", bus.mem_data_r, last_r);

    // ---- reset in the middle of a store to 0x20 ----
    @(posedge clk); #1;
    drive(0, 1, 0, 32'h20, 32'h22222222);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_wait", {31'd0, bus.mem_wait}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wait", {31'd0, bus.mem_wait}, 32'd0);
    chk("mid_rst_data", bus.mem_data_r, 32'd0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    last_r = 32'd0;
    run_access(100, mk(1,0,0, 32'h20, 0, 0, 32'h11111111, 0));
    run_access(101, mk(1,0,0, 32'h10, 0, 0, 32'hDEADBEEF, 0));
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
